// File: rtl/jstk_poll_sched.sv
// jstk_poll_sched: shares one 40-bit SPI master between two joysticks.
// Each poll tick runs START, WAIT, LATCH (or timeout), then GAP, and players alternate.
module jstk_poll_sched #(
    parameter int POLL_DIV = 500000,
    parameter int TIMEOUT  = 4096,
    parameter int GAP      = 750
) (
    input  logic        clk50M,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  led0,
    input  logic [1:0]  led1,
    output logic        spi_start,
    output logic [39:0] spi_tx,
    output logic        cs_sel,
    input  logic        spi_done,
    input  logic [39:0] spi_rx,
    output logic [9:0]  x0,
    output logic [9:0]  y0,
    output logic [9:0]  x1,
    output logic [9:0]  y1,
    output logic [2:0]  btn0,
    output logic [2:0]  btn1,
    output logic        valid0,
    output logic        valid1,
    output logic        err0,
    output logic        err1
);

    localparam int DW = $clog2(POLL_DIV);
    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = $clog2(GAP + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(POLL_DIV - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_LATCH,
        S_GAP
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [DW-1:0] r_div;
    logic          r_pending;
    logic [TW-1:0] r_tmo;
    logic [GW-1:0] r_gap;

    logic          r_cs;
    logic [39:0]   r_tx;
    logic [39:0]   r_rx;

    logic [9:0]    r_x0;
    logic [9:0]    r_y0;
    logic [9:0]    r_x1;
    logic [9:0]    r_y1;
    logic [2:0]    r_btn0;
    logic [2:0]    r_btn1;
    logic          r_valid0;
    logic          r_valid1;
    logic          r_err0;
    logic          r_err1;

    logic          w_tick;
    logic          w_leave_idle;
    logic          w_timeout;
    logic          w_gap_end;
    logic          w_capture;
    logic [1:0]    w_led;
    logic [9:0]    w_x;
    logic [9:0]    w_y;
    logic [2:0]    w_btn;
    logic          w_unused;

    assign w_tick    = (r_div == DIV_LAST);
    assign w_capture = (r_state == S_WAIT) && spi_done;
    assign w_led     = r_cs ? led1 : led0;

    assign w_x   = {r_rx[25:24], r_rx[39:32]};
    assign w_y   = {r_rx[9:8], r_rx[23:16]};
    assign w_btn = r_rx[2:0];

    // Padding bits of the joystick reply carry nothing we use.
    assign w_unused = ^{r_rx[31:26], r_rx[15:10], r_rx[7:3]};

    always_comb begin
        w_next       = r_state;
        w_leave_idle = 1'b0;
        w_timeout    = 1'b0;
        w_gap_end    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending && enable) begin
                    w_next       = S_START;
                    w_leave_idle = 1'b1;
                end
            end
            S_START: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                // A done landing on the last allowed cycle still counts.
                if (spi_done) begin
                    w_next = S_LATCH;
                end else if (r_tmo == TMO_LAST) begin
                    w_next    = S_GAP;
                    w_timeout = 1'b1;
                end
            end
            S_LATCH: begin
                w_next = S_GAP;
            end
            S_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_next    = S_IDLE;
                    w_gap_end = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= '0;
            r_pending <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_leave_idle) begin
                r_pending <= 1'b0;
            end else if (w_tick) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Counts from the START cycle, so WAIT lasts TIMEOUT-1 cycles at most.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
            r_gap <= '0;
        end else begin
            r_tmo <= (w_next == S_WAIT) ? r_tmo + 1'b1 : '0;
            if ((r_state == S_GAP) && !w_gap_end) begin
                r_gap <= r_gap + 1'b1;
            end else begin
                r_gap <= '0;
            end
        end
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            r_cs <= 1'b0;
            r_tx <= '0;
            r_rx <= '0;
        end else begin
            if (w_leave_idle) begin
                r_tx <= {6'b100000, w_led, 32'h0};
            end
            if (w_gap_end) begin
                r_cs <= ~r_cs;
            end
            if (w_capture) begin
                r_rx <= spi_rx;
            end
        end
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            r_x0     <= '0;
            r_y0     <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_btn0   <= '0;
            r_btn1   <= '0;
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
        end else begin
            r_valid0 <= (r_state == S_LATCH) && !r_cs;
            r_valid1 <= (r_state == S_LATCH) && r_cs;
            if (r_state == S_LATCH) begin
                if (r_cs) begin
                    r_x1   <= w_x;
                    r_y1   <= w_y;
                    r_btn1 <= w_btn;
                end else begin
                    r_x0   <= w_x;
                    r_y0   <= w_y;
                    r_btn0 <= w_btn;
                end
            end
        end
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
        end else if (w_timeout) begin
            if (r_cs) begin
                r_err1 <= 1'b1;
            end else begin
                r_err0 <= 1'b1;
            end
        end
    end

    assign spi_start = (r_state == S_START);
    assign spi_tx    = r_tx;
    assign cs_sel    = r_cs;
    assign x0        = r_x0;
    assign y0        = r_y0;
    assign x1        = r_x1;
    assign y1        = r_y1;
    assign btn0      = r_btn0;
    assign btn1      = r_btn1;
    assign valid0    = r_valid0;
    assign valid1    = r_valid1;
    assign err0      = r_err0;
    assign err1      = r_err1;

endmodule

// File: tb/tb_jstk_poll_sched.sv
// tb_jstk_poll_sched: directed bench for the joystick poll scheduler.
// A small SPI responder replies a programmable number of cycles after each start.
module tb_jstk_poll_sched;

    logic        clk50M;
    logic        rst_n;
    logic        enable;
    logic [1:0]  led0;
    logic [1:0]  led1;
    logic        spi_start;
    logic [39:0] spi_tx;
    logic        cs_sel;
    logic        spi_done;
    logic [39:0] spi_rx;
    logic [9:0]  x0;
    logic [9:0]  y0;
    logic [9:0]  x1;
    logic [9:0]  y1;
    logic [2:0]  btn0;
    logic [2:0]  btn1;
    logic        valid0;
    logic        valid1;
    logic        err0;
    logic        err1;

    logic        m_done;
    logic [39:0] m_rx;
    logic        s_done;
    logic [39:0] s_rx;
    logic [39:0] model_rx;
    int          dly0;
    int          dly1;

    int checks;
    int errors;

    assign spi_done = m_done | s_done;
    assign spi_rx   = s_done ? s_rx : m_rx;

    jstk_poll_sched #(
        .POLL_DIV(100),
        .TIMEOUT (50),
        .GAP     (4)
    ) dut (
        .clk50M   (clk50M),
        .rst_n    (rst_n),
        .enable   (enable),
        .led0     (led0),
        .led1     (led1),
        .spi_start(spi_start),
        .spi_tx   (spi_tx),
        .cs_sel   (cs_sel),
        .spi_done (spi_done),
        .spi_rx   (spi_rx),
        .x0       (x0),
        .y0       (y0),
        .x1       (x1),
        .y1       (y1),
        .btn0     (btn0),
        .btn1     (btn1),
        .valid0   (valid0),
        .valid1   (valid1),
        .err0     (err0),
        .err1     (err1)
    );

    initial clk50M = 1'b0;
    always #5 clk50M = ~clk50M;

    // Responder: negative delay means the stick never answers.
    initial begin
        int d;
        m_done = 1'b0;
        m_rx   = '0;
        forever begin
            @(negedge clk50M);
            if (spi_start === 1'b1) begin
                d = cs_sel ? dly1 : dly0;
                if (d >= 0) begin
                    repeat (d) @(negedge clk50M);
                    m_rx   = model_rx;
                    m_done = 1'b1;
                    @(negedge clk50M);
                    m_done = 1'b0;
                end
            end
        end
    end

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(negedge clk50M);
            n++;
        end while (spi_start !== 1'b1 && n < 300);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        enable   = 1'b1;
        led0     = 2'b00;
        led1     = 2'b00;
        s_done   = 1'b0;
        s_rx     = '0;
        model_rx = 40'h3A_02_C5_01_05;
        dly0     = 10;
        dly1     = 10;
        repeat (3) @(negedge clk50M);
        checks++;
        if ({spi_start, spi_tx, cs_sel} !== 42'h0) begin
            errors++;
            $display("FAIL rst_spi got %h want 0", {spi_start, spi_tx, cs_sel});
        end
        checks++;
        if ({x0, y0, x1, y1, btn0, btn1} !== 46'h0) begin
            errors++;
            $display("FAIL rst_pos got %h want 0", {x0, y0, x1, y1, btn0, btn1});
        end
        checks++;
        if ({valid0, valid1, err0, err1} !== 4'h0) begin
            errors++;
            $display("FAIL rst_flags got %b want 0000", {valid0, valid1, err0, err1});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_poll();
        int n;
        int vat;
        int vc0;
        int vc1;
        wait_start(n);
        checks++;
        if (n != 101) begin
            errors++;
            $display("FAIL tick_latency got %0d want 101", n);
        end
        checks++;
        if (cs_sel !== 1'b0 || spi_tx !== 40'h80_0000_0000) begin
            errors++;
            $display("FAIL p0_start got cs=%b tx=%h want cs=0 tx=8000000000", cs_sel, spi_tx);
        end
        vat = -1;
        vc0 = 0;
        vc1 = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk50M);
            if (i == 11) begin
                checks++;
                if (x0 !== 10'h0 || valid0 !== 1'b0) begin
                    errors++;
                    $display("FAIL early_update got x0=%h v=%b want 0/0", x0, valid0);
                end
            end
            if (i == 15) begin
                checks++;
                if (cs_sel !== 1'b0) begin
                    errors++;
                    $display("FAIL cs_hold got %b want 0", cs_sel);
                end
            end
            if (i == 16) begin
                checks++;
                if (cs_sel !== 1'b1) begin
                    errors++;
                    $display("FAIL cs_toggle got %b want 1", cs_sel);
                end
            end
            if (valid0 === 1'b1) begin
                vc0++;
                if (vat < 0) vat = i;
            end
            if (valid1 === 1'b1) vc1++;
        end
        checks++;
        if (vat != 12 || vc0 != 1 || vc1 != 0) begin
            errors++;
            $display("FAIL valid0_pulse got at=%0d n0=%0d n1=%0d want 12/1/0", vat, vc0, vc1);
        end
        checks++;
        if (x0 !== 10'h23A || y0 !== 10'h1C5 || btn0 !== 3'b101) begin
            errors++;
            $display("FAIL p0_data got %h %h %b want 23a 1c5 101", x0, y0, btn0);
        end
        wait_start(n);
        checks++;
        if (cs_sel !== 1'b1 || spi_tx !== 40'h80_0000_0000) begin
            errors++;
            $display("FAIL p1_start got cs=%b tx=%h want cs=1 tx=8000000000", cs_sel, spi_tx);
        end
        repeat (12) @(negedge clk50M);
        checks++;
        if (valid1 !== 1'b1 || x1 !== 10'h23A || y1 !== 10'h1C5 || btn1 !== 3'b101) begin
            errors++;
            $display("FAIL p1_data got v=%b %h %h %b want 1 23a 1c5 101", valid1, x1, y1, btn1);
        end
        checks++;
        if (x0 !== 10'h23A) begin
            errors++;
            $display("FAIL p0_kept got %h want 23a", x0);
        end
    endtask

    task automatic test_command_byte();
        int n;
        led0 = 2'b11;
        led1 = 2'b01;
        wait_start(n);
        checks++;
        if (cs_sel !== 1'b0 || spi_tx !== 40'h83_0000_0000) begin
            errors++;
            $display("FAIL cmd_p0 got cs=%b tx=%h want 0 8300000000", cs_sel, spi_tx);
        end
        wait_start(n);
        checks++;
        if (cs_sel !== 1'b1 || spi_tx !== 40'h81_0000_0000) begin
            errors++;
            $display("FAIL cmd_p1 got cs=%b tx=%h want 1 8100000000", cs_sel, spi_tx);
        end
        repeat (5) @(negedge clk50M);
        led1 = 2'b10;
        repeat (3) @(negedge clk50M);
        checks++;
        if (spi_tx !== 40'h81_0000_0000 || cs_sel !== 1'b1) begin
            errors++;
            $display("FAIL cmd_hold got cs=%b tx=%h want 1 8100000000", cs_sel, spi_tx);
        end
    endtask

    task automatic test_timeout();
        int n;
        int vc1;
        dly1 = -1;
        wait_start(n);
        checks++;
        if (cs_sel !== 1'b0) begin
            errors++;
            $display("FAIL tmo_pre got cs=%b want 0", cs_sel);
        end
        wait_start(n);
        checks++;
        if (cs_sel !== 1'b1 || spi_tx !== 40'h82_0000_0000) begin
            errors++;
            $display("FAIL tmo_start got cs=%b tx=%h want 1 8200000000", cs_sel, spi_tx);
        end
        n   = 0;
        vc1 = 0;
        while (err1 !== 1'b1 && n < 100) begin
            @(negedge clk50M);
            n++;
            if (valid1 === 1'b1) vc1++;
        end
        checks++;
        if (n != 50) begin
            errors++;
            $display("FAIL tmo_latency got %0d want 50", n);
        end
        repeat (10) begin
            @(negedge clk50M);
            if (valid1 === 1'b1) vc1++;
        end
        checks++;
        if (vc1 != 0 || x1 !== 10'h23A || y1 !== 10'h1C5 || btn1 !== 3'b101) begin
            errors++;
            $display("FAIL tmo_untouched got n=%0d %h %h %b want 0 23a 1c5 101", vc1, x1, y1, btn1);
        end
        wait_start(n);
        checks++;
        if (cs_sel !== 1'b0 || err1 !== 1'b1 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL tmo_after got cs=%b e1=%b e0=%b want 0 1 0", cs_sel, err1, err0);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        int vat;
        int vc0;
        dly0 = 49;
        dly1 = 10;
        wait_start(n);
        wait_start(n);
        checks++;
        if (cs_sel !== 1'b0) begin
            errors++;
            $display("FAIL sim_start got cs=%b want 0", cs_sel);
        end
        model_rx = 40'h11_22_33_44_56;
        vat = -1;
        vc0 = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk50M);
            if (valid0 === 1'b1) begin
                vc0++;
                if (vat < 0) vat = i;
            end
        end
        checks++;
        if (vat != 51 || vc0 != 1 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL sim_done_wins got at=%0d n=%0d err0=%b want 51/1/0", vat, vc0, err0);
        end
        checks++;
        if (x0 !== 10'h211 || y0 !== 10'h033 || btn0 !== 3'b110) begin
            errors++;
            $display("FAIL sim_data got %h %h %b want 211 033 110", x0, y0, btn0);
        end
    endtask

    task automatic test_stray_done();
        int n;
        int vc;
        s_rx   = '1;
        s_done = 1'b1;
        @(negedge clk50M);
        s_done = 1'b0;
        vc = 0;
        repeat (3) begin
            @(negedge clk50M);
            if (valid0 === 1'b1 || valid1 === 1'b1 || spi_start === 1'b1) vc++;
        end
        checks++;
        if (vc != 0 || x0 !== 10'h211 || x1 !== 10'h23A || err0 !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle got n=%0d x0=%h x1=%h e0=%b want 0 211 23a 0", vc, x0, x1, err0);
        end
        wait_start(n);
        checks++;
        if (cs_sel !== 1'b1) begin
            errors++;
            $display("FAIL stray_start got cs=%b want 1", cs_sel);
        end
        vc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk50M);
            if (i == 13) s_done = 1'b1;
            if (i == 14) s_done = 1'b0;
            if (valid1 === 1'b1) vc++;
        end
        checks++;
        if (vc != 1 || x1 !== 10'h211 || y1 !== 10'h033 || btn1 !== 3'b110) begin
            errors++;
            $display("FAIL stray_gap got n=%0d %h %h %b want 1 211 033 110", vc, x1, y1, btn1);
        end
    endtask

    task automatic test_enable();
        int n;
        int vat;
        int vc;
        dly0 = 10;
        wait_start(n);
        checks++;
        if (cs_sel !== 1'b0) begin
            errors++;
            $display("FAIL en_start got cs=%b want 0", cs_sel);
        end
        vat = -1;
        vc  = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk50M);
            if (i == 3) enable = 1'b0;
            if (valid0 === 1'b1) begin
                vc++;
                if (vat < 0) vat = i;
            end
        end
        checks++;
        if (vat != 12 || vc != 1) begin
            errors++;
            $display("FAIL en_finish got at=%0d n=%0d want 12/1", vat, vc);
        end
        vc = 0;
        repeat (250) begin
            @(negedge clk50M);
            if (spi_start === 1'b1) vc++;
        end
        checks++;
        if (vc != 0) begin
            errors++;
            $display("FAIL en_hold got %0d starts want 0", vc);
        end
        enable = 1'b1;
        n = 0;
        while (spi_start !== 1'b1 && n < 50) begin
            @(negedge clk50M);
            n++;
        end
        checks++;
        if (n != 1 || cs_sel !== 1'b1) begin
            errors++;
            $display("FAIL en_resume got %0d cycles cs=%b want 1 1", n, cs_sel);
        end
    endtask

    task automatic test_reset_mid();
        int vc;
        repeat (3) @(negedge clk50M);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({spi_start, spi_tx, cs_sel} !== 42'h0) begin
            errors++;
            $display("FAIL midrst_spi got %h want 0", {spi_start, spi_tx, cs_sel});
        end
        checks++;
        if ({x0, y0, x1, y1, btn0, btn1, valid0, valid1, err0, err1} !== 50'h0) begin
            errors++;
            $display("FAIL midrst_out got %h want 0",
                     {x0, y0, x1, y1, btn0, btn1, valid0, valid1, err0, err1});
        end
        repeat (15) @(negedge clk50M);
        rst_n = 1'b1;
        vc = 0;
        repeat (20) begin
            @(negedge clk50M);
            if (valid0 === 1'b1 || valid1 === 1'b1 || err0 === 1'b1 || err1 === 1'b1) vc++;
        end
        checks++;
        if (vc != 0 || x1 !== 10'h0) begin
            errors++;
            $display("FAIL midrst_quiet got n=%0d x1=%h want 0 0", vc, x1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_poll();
        test_command_byte();
        test_timeout();
        test_simultaneous();
        test_stray_done();
        test_enable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
